// File: rtl/trng_word_packer_if.sv
// Handshake bundle between the debiaser-side bit stream, the packer and the bus-side consumer.
// The master modport is the environment driving bits and readiness; slave is the packer.
interface trng_word_packer_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic              in_bit;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              health_fail;
    logic              fail_clear;
    logic [7:0]        words_dropped;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        output fail_clear,
        input  out_data,
        input  out_valid,
        input  health_fail,
        input  words_dropped
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        input  fail_clear,
        output out_data,
        output out_valid,
        output health_fail,
        output words_dropped
    );
endinterface

// File: rtl/trng_word_packer.sv
// Health-tests a debiased serial bit stream (repetition count + adaptive proportion), packs
// healthy bits LSB-first into words and serves them from a small fall-through FIFO.
module trng_word_packer #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_CUTOFF = 16,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 48
) (
    input logic               clk,
    input logic               reset,
    trng_word_packer_if.slave bus
);
    localparam int unsigned CntW  = $clog2(WORD_W);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RunW  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned AptW  = $clog2(APT_WINDOW + 1);

    localparam logic [CntW-1:0]  LastBit   = CntW'(WORD_W - 1);
    localparam logic [FillW-1:0] FillFull  = FillW'(FIFO_DEPTH);
    localparam logic [RunW-1:0]  RunTrip   = RunW'(RCT_CUTOFF);
    localparam logic [AptW-1:0]  AptTrip   = AptW'(APT_CUTOFF);
    localparam logic [AptW-1:0]  AptWinEnd = AptW'(APT_WINDOW);

    typedef enum logic [0:0] {StRun, StFail} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              prev_q, prev_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [AptW-1:0]   apt_pos_q, apt_pos_d;
    logic              apt_ref_q, apt_ref_d;
    logic [AptW-1:0]   apt_cnt_q, apt_cnt_d;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0]  fill_q;
    logic [7:0]        dropped_q;

    logic              accept, trip, push, flush, pop, full, do_write, drop;
    logic [RunW-1:0]   run_next;
    logic [AptW-1:0]   apt_cnt_next, apt_pos_next;
    logic              apt_ref_next;
    logic [WORD_W-1:0] word_next;

    // Health-test and packing next state; a trip wipes everything back to the empty state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prev_d       = prev_q;
        run_d        = run_q;
        apt_pos_d    = apt_pos_q;
        apt_ref_d    = apt_ref_q;
        apt_cnt_d    = apt_cnt_q;
        push         = 1'b0;

        accept = bus.in_valid && (state_q == StRun);

        run_next = (run_q != '0 && bus.in_bit == prev_q) ? run_q + RunW'(1) : RunW'(1);

        if (apt_pos_q == '0) begin
            apt_ref_next = bus.in_bit;
            apt_cnt_next = AptW'(1);
        end else begin
            apt_ref_next = apt_ref_q;
            apt_cnt_next = apt_cnt_q + AptW'(bus.in_bit == apt_ref_q);
        end
        apt_pos_next = apt_pos_q + AptW'(1);
        if (apt_pos_next == AptWinEnd) begin
            apt_pos_next = '0;
        end

        word_next           = shift_q;
        word_next[bit_cnt_q] = bus.in_bit;

        trip = accept && (run_next == RunTrip || apt_cnt_next == AptTrip);

        unique case (state_q)
            StRun: begin
                if (trip) begin
                    state_d   = StFail;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    prev_d    = 1'b0;
                    run_d     = '0;
                    apt_pos_d = '0;
                    apt_ref_d = 1'b0;
                    apt_cnt_d = '0;
                end else if (accept) begin
                    shift_d   = word_next;
                    prev_d    = bus.in_bit;
                    run_d     = run_next;
                    apt_pos_d = apt_pos_next;
                    apt_ref_d = apt_ref_next;
                    apt_cnt_d = apt_cnt_next;
                    if (bit_cnt_q == LastBit) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StFail: begin
                if (bus.fail_clear) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StRun;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            prev_q    <= 1'b0;
            run_q     <= '0;
            apt_pos_q <= '0;
            apt_ref_q <= 1'b0;
            apt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            apt_pos_q <= apt_pos_d;
            apt_ref_q <= apt_ref_d;
            apt_cnt_q <= apt_cnt_d;
        end
    end

    always_comb begin
        flush    = trip || (state_q == StFail);
        full     = (fill_q == FillFull);
        pop      = bus.out_valid && bus.out_ready;
        do_write = push && (!full || pop);
        drop     = push && full && !pop;
    end

    assign bus.out_valid     = (fill_q != '0);
    assign bus.out_data      = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.health_fail   = (state_q == StFail);
    assign bus.words_dropped = dropped_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            dropped_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_write, pop})
                2'b10:   fill_q <= fill_q + FillW'(1);
                2'b01:   fill_q <= fill_q - FillW'(1);
                default: fill_q <= fill_q;
            endcase
            if (drop && dropped_q != 8'hFF) begin
                dropped_q <= dropped_q + 8'd1;
            end
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_write && !flush) begin
            mem_q[wr_ptr_q] <= word_next;
        end
    end
endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
- Sits directly downstream of the Markov debiaser (trng).
- Consumes its serial debiased stream (out / out_valid) and runs continuous SP800-90B-style health tests on that stream: a repetition count test (RCT) and an adaptive proportion test (APT).
- Packs healthy bits into WORD_W-bit words and buffers them in a small FIFO.
- Presents the words to the system bus on a valid/ready interface.

Parameters:
- WORD_W, 32, bits per output word.
- FIFO_DEPTH, 4, number of output words buffered (power of two).
- RCT_CUTOFF, 16, run length of identical bits that declares failure.
- APT_WINDOW, 64, APT window length in bits.
- APT_CUTOFF, 48, count of the window's reference bit that declares failure.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge).
- in_valid  in  1  debiased bit strobe (from trng out_valid).
- in_bit  in  1  debiased bit (from trng out).
- out_data  out  WORD_W  packed random word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- health_fail  out  1  sticky health-test failure flag.
- fail_clear  in  1  single-cycle pulse that clears a failure.
- words_dropped  out  8  saturating count of words lost to a full FIFO.

Behaviour:
- Reset (reset==0 at a clk edge):
  - out_valid=0, out_data=0, health_fail=0, words_dropped=0.
  - FIFO is emptied; bit counter, shift register, RCT state and APT state are cleared.
  - State becomes RUN.
  - Reset mid-word discards the partial word. Reset takes priority over every other input.
- States are RUN and FAIL.
  - RUN -> FAIL when either health test trips.
  - FAIL -> RUN on fail_clear==1.
  - fail_clear in RUN is ignored.
- Bit acceptance:
  - A bit is accepted when in_valid==1 and state==RUN.
  - in_valid in FAIL is ignored.
- Packing:
  - Packing is LSB-first: the k-th accepted bit of a word lands in bit k-1.
  - On the cycle the WORD_W-th bit is accepted, the completed word is pushed to the FIFO and the bit counter wraps to 0.
- Latency: last bit accepted at edge N with the FIFO empty -> out_valid=1 with that word at edge N+1.
- RCT:
  - The first bit after reset or clear sets run=1.
  - Each later bit does run+1 if it equals the previous bit, otherwise run=1.
  - run reaching RCT_CUTOFF trips.
- APT:
  - The first bit of each window is the reference, and the count starts at 1.
  - Each later bit in the window increments the count if it equals the reference.
  - The count reaching APT_CUTOFF trips.
  - After APT_WINDOW bits the next bit starts a new window.
- Trip handling:
  - Trip on the bit accepted at edge N: health_fail=1 at N+1, state=FAIL.
  - The tripping bit and the partial word are discarded.
  - The word containing the tripping bit is never pushed, even if the tripping bit was its last bit.
- While in FAIL:
  - The FIFO is flushed, so out_valid=0 from N+1.
  - No pops occur.
  - health_fail stays 1 until fail_clear.
- fail_clear (in FAIL):
  - At the next edge health_fail=0 and state=RUN.
  - RCT, APT and packing restart from an empty state.
  - words_dropped is not cleared.
- FIFO:
  - A pop happens when out_valid && out_ready.
  - out_data/out_valid hold stable until popped.
  - Output is first-word fall-through from the FIFO head.
  - Push while full without a same-cycle pop: the new word is dropped and words_dropped increments, saturating at 255.
  - Push while full with a same-cycle pop: the push succeeds and nothing is dropped.
  - Push and pop on the same cycle with the FIFO empty is impossible because the word is not yet visible; the word appears next cycle.
- out_ready is ignored while out_valid==0.

Test Plan:
- Alternating bits 1,0,1,0,... for 32 accepted bits, out_ready=1 -> one word out_data=32'h5555_5555, out_valid high for 1 cycle, health_fail=0.
- 15 ones, then a 0, then 16 more bits of alternating 0,1 (32 bits in total) -> no trip and one word emitted. Separately, 16 consecutive ones -> health_fail=1 on the edge after the 16th bit, out_valid=0, no word emitted.
- Pattern 1110 repeated 16 times (64 bits) -> APT trips on bit 63 (48th one), health_fail=1, and no word is emitted containing bit 63 (first word 32'h7777_7777 emitted). Same test with pattern 10 -> no trip.
- out_ready=0 with 5 full words fed -> 4 buffered, words_dropped=1. Then out_ready=1 -> 4 words popped in order on consecutive cycles, then out_valid=0.
- In FAIL, pulse fail_clear, then feed 32'hA5A5_A5A5 LSB-first -> word 32'hA5A5_A5A5 emitted, health_fail=0, words_dropped unchanged.
- Assert reset (0) after 20 bits of a word, release, then feed 32 alternating bits -> output is 32'h5555_5555 with no residue from the partial word; all outputs read reset values during reset.
